radix2_product_divider: RTL and testbench
=========================================

# radix2_product_divider

Iterative signed divider that inverts the Booth multiplier datapath: it takes a 2N-bit signed product and an N-bit signed operand and recovers the N-bit signed quotient and remainder. The block is a restoring radix-2 engine with a start/busy/done handshake. It sits beside the multiplier array for product self-check and for normalisation/scaling of accumulated systolic-array results.

## Interface
- N, 8, operand width; dividend is 2N bits, quotient and remainder are N bits; N ≥ 4
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-low reset (0 = reset)
- start  in  1  request; sampled only in IDLE
- dividend  in  2N  signed dividend (e.g. a Prod value); sampled with start
- divisor  in  N  signed divisor; sampled with start
- quotient  out  N  signed quotient, truncated toward zero
- remainder  out  N  signed remainder; sign follows dividend
- busy  out  1  high while an operation is in flight
- done  out  1  one-cycle pulse; results and flags valid from this cycle
- div_by_zero  out  1  last result had divisor == 0
- overflow  out  1  last true quotient was outside [-2^(N-1), 2^(N-1)-1]

## Operation
- States: IDLE, DIV, FIX.
- IDLE, start=1 at an edge:
  - latch |dividend| (2N-bit unsigned) and |divisor| (N-bit unsigned);
  - latch sign_q = dividend[2N-1] ^ divisor[N-1] and sign_r = dividend[2N-1];
  - latch zero flag (divisor == 0);
  - clear the partial remainder (N+1 bits) and the iteration counter; go to DIV.
- IDLE, start=0: hold. All outputs keep the values from the last result.
- DIV runs exactly 2N iterations, one per cycle. Each iteration:
  - shift the MSB of the magnitude dividend into the partial remainder;
  - trial-subtract |divisor|; if non-negative, keep the difference and shift in quotient bit 1, else restore and shift in 0.
  - This produces a 2N-bit magnitude quotient Qm and an N-bit magnitude remainder Rm.
- A zero divisor still runs the full DIV sequence, so latency is uniform.
- At the end of iteration 2N, go to FIX.
- FIX (1 cycle) registers the outputs, pulses done and returns to IDLE. Decision order:
  - zero divisor: quotient = 0, remainder = 0, div_by_zero = 1, overflow = 0;
  - else if (sign_q=0 and Qm > 2^(N-1)-1) or (sign_q=1 and Qm > 2^(N-1)): quotient = 0, remainder = 0, overflow = 1, div_by_zero = 0;
  - else: quotient = sign_q ? -Qm[N-1:0] : Qm[N-1:0] and remainder = sign_r ? -Rm : Rm, both flags 0.
- -2^(2N-1) as dividend is legal: its magnitude fits in 2N unsigned bits.
- A negative result with Qm == 2^(N-1) yields quotient = -2^(N-1) with no overflow.
- start while busy = 1 is ignored; no queueing.

## Timing
- Reset (rst=0, asynchronous): state IDLE; quotient, remainder, busy, done, div_by_zero and overflow all 0; internal registers cleared.
- Start accepted at edge E0. busy = 1 from E0 to E0+2N+1. done = 1 for exactly one cycle after edge E0+2N+1, with busy = 0 in that same cycle.
- Latency is 2N+1 cycles from the start edge to the done cycle (17 for N=8), independent of operand values.
- Outputs change only at the FIX edge. Between done pulses they are stable.
- start = 1 in the done cycle is accepted at the next edge. Back-to-back throughput is one result per 2N+1 cycles.
- Inputs are don't-care except at the accepting edge.
- rst asserted mid-operation aborts the operation: no done pulse, all outputs go to 0. After rst is released the block waits in IDLE for a new start.

## Test plan
- Reset/idle: hold rst=0 for 3 cycles, release, start=0 for 40 cycles. All outputs stay 0 and done never pulses.
- Signed recovery (N=8), each starting with done seen 17 cycles after the start edge:
  - -24/4 → q=-6, r=0;
  - 16129/127 → q=127, r=0;
  - 126/-1 → q=-126, r=0;
  - 0/15 → q=0, r=0.
- Truncation and sign rules:
  - 17/-5 → q=-3, r=2;
  - -17/5 → q=-3, r=-2;
  - -17/-5 → q=3, r=-2.
- Range boundaries:
  - -128/1 and 128/-1 → q=-128, overflow=0;
  - 128/1 → overflow=1, q=0, r=0;
  - -32768/-1 → overflow=1;
  - 5/0 → div_by_zero=1, overflow=0, q=0, r=0.
- Handshake:
  - pulse start again 5 cycles after accept with different operands; it is ignored and the first result is returned;
  - raise start in the done cycle; the second result's done arrives exactly 17 cycles later.
- Reset mid-op: assert rst 8 cycles after start. Outputs go to 0 immediately and no done pulse occurs. A new operation after release completes correctly.

Source files
------------

// File: rtl/radix2_product_divider.sv
// radix2_product_divider
// Restoring radix-2 signed divider: recovers an N-bit quotient and remainder
// from a 2N-bit signed dividend (typically a multiplier product) and an N-bit
// signed divisor. The sequencer always runs 2N shift/subtract iterations and
// then one fix-up cycle, so latency does not depend on the operand values.
module radix2_product_divider #(
    parameter int N = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [2*N-1:0] dividend,
    input  logic [N-1:0]   divisor,
    output logic [N-1:0]   quotient,
    output logic [N-1:0]   remainder,
    output logic           busy,
    output logic           done,
    output logic           div_by_zero,
    output logic           overflow
);

    localparam int CW = $clog2(2 * N);
    localparam logic [CW-1:0]  CNT_ONE  = CW'(1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(2 * N - 1);
    localparam logic [N-1:0]   ONE_N    = N'(1);
    localparam logic [2*N-1:0] ONE_2N   = (2 * N)'(1);
    // Largest positive quotient magnitude, and largest negative one.
    localparam logic [2*N-1:0] QPOS = {{(N + 1){1'b0}}, {(N - 1){1'b1}}};
    localparam logic [2*N-1:0] QNEG = {{N{1'b0}}, 1'b1, {(N - 1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DIV  = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_next;

    logic [2*N-1:0]  r_dvd;      // magnitude dividend; quotient bits shift in at LSB
    logic [N-1:0]    r_dvs;      // magnitude divisor
    logic [N-1:0]    r_prem;     // partial remainder (always < |divisor|)
    logic [CW-1:0]   r_cnt;
    logic            r_sign_q;
    logic            r_sign_r;
    logic            r_zero;

    logic [N-1:0]    r_quotient;
    logic [N-1:0]    r_remainder;
    logic            r_busy;
    logic            r_done;
    logic            r_dbz;
    logic            r_ovf;

    logic [N:0]      w_shift;
    logic            w_ge;
    logic [N-1:0]    w_sub;
    logic            w_ovf;

    // Magnitude of a 2N-bit two's-complement value; -2^(2N-1) maps to 2^(2N-1).
    function automatic logic [2*N-1:0] f_mag_dvd(input logic [2*N-1:0] x);
        return x[2*N-1] ? (~x + ONE_2N) : x;
    endfunction

    // Magnitude of an N-bit two's-complement value.
    function automatic logic [N-1:0] f_mag_dvs(input logic [N-1:0] x);
        return x[N-1] ? (~x + ONE_N) : x;
    endfunction

    // Re-apply a sign to an N-bit magnitude.
    function automatic logic [N-1:0] f_apply_sign(input logic [N-1:0] m, input logic neg);
        return neg ? (~m + ONE_N) : m;
    endfunction

    // The partial remainder before the shift is below |divisor| <= 2^(N-1),
    // so the shifted value needs N+1 bits but a successful difference fits in N.
    assign w_shift = {r_prem, r_dvd[2*N-1]};
    assign w_ge    = (w_shift >= {1'b0, r_dvs});
    assign w_sub   = w_shift[N-1:0] - r_dvs;
    assign w_ovf   = r_sign_q ? (r_dvd > QNEG) : (r_dvd > QPOS);

    assign quotient    = r_quotient;
    assign remainder   = r_remainder;
    assign busy        = r_busy;
    assign done        = r_done;
    assign div_by_zero = r_dbz;
    assign overflow    = r_ovf;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic: accept in IDLE, 2N iterations in DIV, one FIX cycle.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = S_DIV;
            S_DIV:   if (r_cnt == CNT_LAST) w_next = S_FIX;
            S_FIX:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Operand capture, shift/subtract iterations and result registration.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_dvd       <= '0;
            r_dvs       <= '0;
            r_prem      <= '0;
            r_cnt       <= '0;
            r_sign_q    <= 1'b0;
            r_sign_r    <= 1'b0;
            r_zero      <= 1'b0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_dbz       <= 1'b0;
            r_ovf       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_dvd    <= f_mag_dvd(dividend);
                        r_dvs    <= f_mag_dvs(divisor);
                        r_sign_q <= dividend[2*N-1] ^ divisor[N-1];
                        r_sign_r <= dividend[2*N-1];
                        r_zero   <= (divisor == '0);
                        r_prem   <= '0;
                        r_cnt    <= '0;
                        r_busy   <= 1'b1;
                    end
                end
                S_DIV: begin
                    r_prem <= w_ge ? w_sub : w_shift[N-1:0];
                    r_dvd  <= {r_dvd[2*N-2:0], w_ge};
                    r_cnt  <= r_cnt + CNT_ONE;
                end
                S_FIX: begin
                    r_done <= 1'b1;
                    r_busy <= 1'b0;
                    if (r_zero) begin
                        r_quotient  <= '0;
                        r_remainder <= '0;
                        r_dbz       <= 1'b1;
                        r_ovf       <= 1'b0;
                    end else if (w_ovf) begin
                        r_quotient  <= '0;
                        r_remainder <= '0;
                        r_dbz       <= 1'b0;
                        r_ovf       <= 1'b1;
                    end else begin
                        r_quotient  <= f_apply_sign(r_dvd[N-1:0], r_sign_q);
                        r_remainder <= f_apply_sign(r_prem, r_sign_r);
                        r_dbz       <= 1'b0;
                        r_ovf       <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_radix2_product_divider.sv
// Scoreboard bench for radix2_product_divider (N = 8): the stimulus side
// queues hand-computed results; a monitor checks every done pulse against
// the queue head, including the 17-cycle start-to-done latency.
module tb_radix2_product_divider;

    logic              clk;
    logic              rst;
    logic              start;
    logic [15:0]       dividend;
    logic [7:0]        divisor;
    logic [7:0]        quotient;
    logic [7:0]        remainder;
    logic              busy;
    logic              done;
    logic              div_by_zero;
    logic              overflow;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    typedef struct {
        string tag;
        int    q;
        int    r;
        int    dbz;
        int    ovf;
        int    due;
    } exp_t;

    exp_t q_exp[$];

    // Directed vectors: dividend, divisor, quotient, remainder, div_by_zero, overflow.
    int tv_a[13]   = '{-24, 16129, 126, 0, 17, -17, -17, -128, 128, 128, 129, -32768, 5};
    int tv_b[13]   = '{4,   127,   -1,  15, -5, 5,   -5,  1,    -1,  1,   -1,  -1,     0};
    int tv_q[13]   = '{-6,  127,  -126, 0,  -3, -3,  3,   -128, -128, 0,  0,   0,      0};
    int tv_r[13]   = '{0,   0,     0,   0,  2,  -2,  -2,  0,    0,   0,   0,   0,      0};
    int tv_dbz[13] = '{0,   0,     0,   0,  0,  0,   0,   0,    0,   0,   0,   0,      1};
    int tv_ovf[13] = '{0,   0,     0,   0,  0,  0,   0,   0,    0,   1,   1,   1,      0};

    radix2_product_divider #(.N(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .quotient    (quotient),
        .remainder   (remainder),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .overflow    (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // Present one operation; optionally queue its expected result.
    task automatic issue(input int a, input int b, input bit push, input string tag,
                         input int eq, input int er, input int edbz, input int eovf);
        exp_t e;
        @(posedge clk);
        #1;
        start    = 1'b1;
        dividend = 16'(a);
        divisor  = 8'(b);
        if (push) begin
            e.tag = tag; e.q = eq; e.r = er; e.dbz = edbz; e.ovf = eovf;
            e.due = cyc + 18;
            q_exp.push_back(e);
        end
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Wait (bounded) until every queued result has been checked.
    task automatic drain(input string tag);
        for (int i = 0; i < 60; i++) begin
            if (q_exp.size() == 0) break;
            @(negedge clk);
            #1;
        end
        if (q_exp.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s_timeout: got no done, expected %0d pending result(s)", tag, q_exp.size());
            q_exp.delete();
        end
    endtask

    // Monitor: compare every done pulse against the scoreboard head.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst && done) begin
                if (q_exp.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_done: got done=1 at cycle %0d, expected none", cyc);
                end else begin
                    e = q_exp.pop_front();
                    chk({e.tag, "_q"},       $signed(quotient),  e.q);
                    chk({e.tag, "_r"},       $signed(remainder), e.r);
                    chk({e.tag, "_dbz"},     int'(div_by_zero),  e.dbz);
                    chk({e.tag, "_ovf"},     int'(overflow),     e.ovf);
                    chk({e.tag, "_busy"},    int'(busy),         0);
                    chk({e.tag, "_latency"}, cyc,                e.due);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, expected end of run");
        $fatal(1, "timeout");
    end

    initial begin
        rst      = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;

        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            chk("idle_outputs", int'({quotient, remainder, busy, done, div_by_zero, overflow}), 0);
        end

        for (int i = 0; i < 13; i++) begin
            issue(tv_a[i], tv_b[i], 1'b1, $sformatf("vec%0d", i),
                  tv_q[i], tv_r[i], tv_dbz[i], tv_ovf[i]);
            drain($sformatf("vec%0d", i));
        end

        // start while busy is ignored; only 100/7 comes back
        issue(100, 7, 1'b1, "busy_ignore", 14, 2, 0, 0);
        repeat (4) @(posedge clk);
        #1;
        start    = 1'b1;
        dividend = 16'(50);
        divisor  = 8'(3);
        @(posedge clk);
        #1;
        start = 1'b0;
        drain("busy_ignore");

        // start raised in the done cycle is accepted at the next edge
        begin
            exp_t e;
            bit   seen;
            issue(1000, -9, 1'b1, "b2b_first", -111, 1, 0, 0);
            seen = 1'b0;
            for (int i = 0; i < 40; i++) begin
                @(negedge clk);
                if (done) begin
                    seen = 1'b1;
                    break;
                end
            end
            chk("b2b_done_seen", int'(seen), 1);
            start    = 1'b1;
            dividend = 16'(-200);
            divisor  = 8'(13);
            e.tag = "b2b_second"; e.q = -15; e.r = -5; e.dbz = 0; e.ovf = 0;
            e.due = cyc + 18;
            q_exp.push_back(e);
            @(posedge clk);
            #1;
            start = 1'b0;
            drain("b2b");
        end

        // reset mid-operation aborts with no done pulse
        issue(-24, 4, 1'b0, "abort", 0, 0, 0, 0);
        repeat (8) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("abort_outputs", int'({quotient, remainder, busy, done, div_by_zero, overflow}), 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (25) @(negedge clk);
        chk("abort_idle_busy", int'(busy), 0);

        issue(77, -8, 1'b1, "after_abort", -9, 5, 0, 0);
        drain("after_abort");

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
